mc_ctrl: RTL and testbench

//  Multi-cycle MIPS control unit: a Moore FSM sequencing FETCH/DECODE/EXEC/MEM/WB over shared datapath.

---
 rtl/mc_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing FETCH/DECODE/EXEC/MEM/WB over a shared datapath.
// Latency: R/I-ALU 4, lw 5, sw 4, branch/jump 3 cycles at zero wait; each memory wait cycle adds one.
// Backpressure: MC_CTRL_MEMWAIT_EN defined -> memory states hold until mem_ready; else each lasts MEM_LAT cycles.
module mc_ctrl #(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             ir_we,
    output logic             mem_re,
    output logic             mem_we,
    output logic             reg_we,
    output logic             ext_op,
    output logic             alu_srca,
    output logic [1:0]       alu_srcb,
    output logic [3:0]       alu_op,
    output logic [1:0]       npc_op,
    output logic [1:0]       gpr_sel,
    output logic [1:0]       wd_sel,
    output logic [3:0]       state,
    output logic             illegal,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWR  = 4'd4,
        S_WB_ALU = 4'd5,
        S_WB_MEM = 4'd6,
        S_BRANCH = 4'd7,
        S_JUMP   = 4'd8
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_retired;
    logic             w_mem_done;
    logic             w_done;

    // Instruction decode shared by DECODE/EXEC/WB
    logic       w_legal, w_rtype, w_ext, w_is_lw, w_is_sw;
    logic       w_is_beq, w_is_bne, w_is_j, w_is_jal;
    logic [3:0] w_alu;

    assign w_rtype  = (op == 6'h00);
    assign w_is_lw  = (op == 6'h23);
    assign w_is_sw  = (op == 6'h2B);
    assign w_is_beq = (op == 6'h04);
    assign w_is_bne = (op == 6'h05);
    assign w_is_j   = (op == 6'h02);
    assign w_is_jal = (op == 6'h03);

    // ALU operation, sign-extension and legality from op/funct
    always_comb begin
        w_legal = 1'b1;
        w_ext   = 1'b0;
        w_alu   = 4'd0;
        if (w_rtype) begin
            case (funct)
                6'h20, 6'h21: w_alu = 4'd1;
                6'h22, 6'h23: w_alu = 4'd2;
                6'h24:        w_alu = 4'd3;
                6'h25:        w_alu = 4'd4;
                6'h2A:        w_alu = 4'd5;
                6'h2B:        w_alu = 4'd6;
                6'h00:        w_alu = 4'd7;
                6'h27:        w_alu = 4'd8;
                6'h04:        w_alu = 4'd10;
                default:      w_legal = 1'b0;
            endcase
        end else begin
            case (op)
                6'h08, 6'h23, 6'h2B: begin w_alu = 4'd1; w_ext = 1'b1; end
                6'h0D:               w_alu = 4'd4;
                6'h0F:               w_alu = 4'd9;
                6'h0A:               begin w_alu = 4'd5; w_ext = 1'b1; end
                6'h0C:               begin w_alu = 4'd3; w_ext = 1'b1; end
                6'h04, 6'h05, 6'h02, 6'h03: ;
                default:             w_legal = 1'b0;
            endcase
        end
    end

`ifdef MC_CTRL_MEMWAIT_EN
    assign w_mem_done = mem_ready;
`else
    localparam int WAIT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    logic [WAIT_W-1:0] r_wait;
    logic              w_mem_st;
    logic              w_unused_mem_ready;

    assign w_unused_mem_ready = mem_ready;
    assign w_mem_st   = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign w_mem_done = (r_wait == WAIT_W'(MEM_LAT - 1));

    // Fixed-latency wait counter; cleared on completion (which is also state exit)
    always_ff @(posedge clk) begin
        if (!rstn)                    r_wait <= '0;
        else if (w_mem_st && !w_mem_done) r_wait <= r_wait + 1'b1;
        else                          r_wait <= '0;
    end
`endif

    // State sequencing
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:  if (w_mem_done) r_state <= S_DECODE;
                S_DECODE: begin
                    if (!w_legal)                  r_state <= S_FETCH;
                    else if (w_is_beq || w_is_bne) r_state <= S_BRANCH;
                    else if (w_is_j || w_is_jal)   r_state <= S_JUMP;
                    else                           r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (w_is_lw)      r_state <= S_MEMRD;
                    else if (w_is_sw) r_state <= S_MEMWR;
                    else              r_state <= S_WB_ALU;
                end
                S_MEMRD:  if (w_mem_done) r_state <= S_WB_MEM;
                S_MEMWR:  if (w_mem_done) r_state <= S_FETCH;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk) begin
        if (!rstn)       r_retired <= '0;
        else if (w_done) r_retired <= r_retired + 1'b1;
    end

    assign w_done  = ((r_state == S_MEMWR) && w_mem_done) || (r_state == S_WB_ALU) ||
                     (r_state == S_WB_MEM) || (r_state == S_BRANCH) || (r_state == S_JUMP);
    assign state   = r_state;
    assign retired = r_retired;

    // Datapath controls from state and instruction; strobes forced low during reset
    always_comb begin
        pc_we = 1'b0; ir_we = 1'b0; mem_re = 1'b0; mem_we = 1'b0; reg_we = 1'b0;
        ext_op = 1'b0; alu_srca = 1'b0; alu_srcb = 2'b00; alu_op = 4'd0;
        npc_op = 2'b00; gpr_sel = 2'b00; wd_sel = 2'b00; illegal = 1'b0;
        instr_done = w_done;
        case (r_state)
            S_FETCH: begin
                mem_re   = 1'b1;
                alu_srcb = 2'b01;
                alu_op   = 4'd1;
                pc_we    = w_mem_done;
                ir_we    = w_mem_done;
            end
            S_DECODE: illegal = !w_legal;
            S_EXEC: begin
                alu_srca = 1'b1;
                alu_srcb = w_rtype ? 2'b00 : 2'b10;
                alu_op   = w_alu;
                ext_op   = w_ext;
            end
            S_MEMRD: mem_re = 1'b1;
            S_MEMWR: mem_we = 1'b1;
            S_WB_ALU: begin
                reg_we  = 1'b1;
                gpr_sel = w_rtype ? 2'b00 : 2'b01;
            end
            S_WB_MEM: begin
                reg_we  = 1'b1;
                wd_sel  = 2'b01;
                gpr_sel = 2'b01;
            end
            S_BRANCH: begin
                alu_srca = 1'b1;
                alu_op   = 4'd2;
                npc_op   = 2'b01;
                pc_we    = (w_is_beq && zero) || (w_is_bne && !zero);
            end
            S_JUMP: begin
                npc_op = 2'b10;
                pc_we  = 1'b1;
                if (w_is_jal) begin
                    reg_we  = 1'b1;
                    gpr_sel = 2'b10;
                    wd_sel  = 2'b10;
                end
            end
            default: ;
        endcase
        if (!rstn) begin
            pc_we = 1'b0; ir_we = 1'b0; mem_re = 1'b0; mem_we = 1'b0; reg_we = 1'b0;
            illegal = 1'b0; instr_done = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: scoreboard of per-instruction expectations vs observed behaviour.
// Each instruction is run from its first FETCH cycle to its retire/illegal cycle.
// Memory waits are injected on mem_ready when the handshake build is selected.
module tb_mc_ctrl;

    localparam int LAT = 3;
    localparam int CW  = 4;

    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4,
                   K_BNE = 5, K_J = 6, K_JAL = 7, K_ILL = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic [5:0]    op, funct;
    logic          zero, mem_ready;
    logic          pc_we, ir_we, mem_re, mem_we, reg_we, ext_op, alu_srca;
    logic [1:0]    alu_srcb, npc_op, gpr_sel, wd_sel;
    logic [3:0]    alu_op, state;
    logic          illegal, instr_done;
    logic [CW-1:0] retired;

    mc_ctrl #(.MEM_LAT(LAT), .CNT_W(CW)) dut (
        .clk(clk), .rstn(rstn), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_we(pc_we), .ir_we(ir_we), .mem_re(mem_re), .mem_we(mem_we), .reg_we(reg_we),
        .ext_op(ext_op), .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_op(alu_op),
        .npc_op(npc_op), .gpr_sel(gpr_sel), .wd_sel(wd_sel), .state(state),
        .illegal(illegal), .instr_done(instr_done), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc; int ill; int nreg; int nmemwe; int nmemrd; int npc;
        int gpr; int wd; int npcop; int alu; int last;
    } rec_t;

    rec_t          sb[$];
    int            n_chk = 0;
    int            n_err = 0;
    logic [CW-1:0] exp_ret;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Entered just after a rising edge with the DUT in the first FETCH cycle.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int w, input int kind, input int alu);
        rec_t e, g;
        int   fl, ml, waited;
`ifdef MC_CTRL_MEMWAIT_EN
        fl = 1; ml = 1 + w;
`else
        fl = LAT; ml = LAT;
`endif
        e = '{default: 0};
        e.alu = alu;
        e.npc = 1;
        case (kind)
            K_R:   begin e.cyc = fl + 3; e.nreg = 1; e.last = 5; end
            K_I:   begin e.cyc = fl + 3; e.nreg = 1; e.last = 5; e.gpr = 1; end
            K_LW:  begin e.cyc = fl + 3 + ml; e.nreg = 1; e.nmemrd = ml; e.last = 6; e.gpr = 1; e.wd = 1; end
            K_SW:  begin e.cyc = fl + 2 + ml; e.nmemwe = ml; e.last = 4; end
            K_BEQ: begin e.cyc = fl + 2; e.last = 7; e.npcop = 1; e.npc = z ? 2 : 1; end
            K_BNE: begin e.cyc = fl + 2; e.last = 7; e.npcop = 1; e.npc = z ? 1 : 2; end
            K_J:   begin e.cyc = fl + 2; e.last = 8; e.npcop = 2; e.npc = 2; end
            K_JAL: begin e.cyc = fl + 2; e.last = 8; e.npcop = 2; e.npc = 2; e.nreg = 1; e.gpr = 2; e.wd = 2; end
            default: begin e.cyc = fl + 1; e.ill = 1; e.last = 1; end
        endcase
        sb.push_back(e);

        op = o; funct = f; zero = z;
        g = '{default: 0};
        waited = 0;
        while (1) begin
`ifdef MC_CTRL_MEMWAIT_EN
            if ((state == 4'd3 || state == 4'd4) && waited < w) begin
                mem_ready = 1'b0; waited++;
            end else begin
                mem_ready = 1'b1;
            end
`else
            mem_ready = 1'($urandom_range(0, 1));
`endif
            @(negedge clk);
            g.cyc++;
            if (g.cyc == 1) begin
                chk("start_state", state, 0);
                chk("start_retired", retired, exp_ret);
                chk("fetch_mem_re", mem_re, 1);
            end
            g.nreg   += reg_we;
            g.nmemwe += mem_we;
            g.npc    += pc_we;
            if (state == 4'd3) g.nmemrd += mem_re;
            if (state == 4'd2 || state == 4'd7) g.alu = alu_op;
            if (instr_done || illegal || g.cyc >= 60) begin
                g.ill = illegal; g.gpr = gpr_sel; g.wd = wd_sel; g.npcop = npc_op; g.last = state;
                if (g.cyc >= 60) chk("timeout", 1, 0);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;

        e = sb.pop_front();
        chk("cycles", g.cyc, e.cyc);
        chk("illegal", g.ill, e.ill);
        chk("last_state", g.last, e.last);
        chk("reg_we_cnt", g.nreg, e.nreg);
        chk("mem_we_cnt", g.nmemwe, e.nmemwe);
        chk("memrd_re_cnt", g.nmemrd, e.nmemrd);
        chk("pc_we_cnt", g.npc, e.npc);
        chk("gpr_sel", g.gpr, e.gpr);
        chk("wd_sel", g.wd, e.wd);
        chk("npc_op", g.npcop, e.npcop);
        chk("alu_op", g.alu, e.alu);
        if (!e.ill) exp_ret = exp_ret + 1'b1;
        chk("retired", retired, exp_ret);
    endtask

    initial begin
        rstn = 1'b0; op = 6'h00; funct = 6'h20; zero = 1'b0; mem_ready = 1'b1;
        exp_ret = '0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_retired", retired, 0);
        chk("rst_strobes", {pc_we, ir_we, mem_re, mem_we, reg_we, illegal, instr_done}, 0);
        @(posedge clk); #1;
        rstn = 1'b1;

        run_instr(6'h00, 6'h20, 1'b0, 0, K_R,   1);   // add
        run_instr(6'h00, 6'h22, 1'b0, 0, K_R,   2);   // sub
        run_instr(6'h00, 6'h00, 1'b0, 0, K_R,   7);   // sll
        run_instr(6'h0D, 6'h3F, 1'b0, 0, K_I,   4);   // ori
        run_instr(6'h0F, 6'h00, 1'b0, 0, K_I,   9);   // lui
        run_instr(6'h23, 6'h00, 1'b0, 3, K_LW,  1);   // lw, 3 wait cycles in MEMRD
        run_instr(6'h2B, 6'h00, 1'b0, 1, K_SW,  1);   // sw
        run_instr(6'h04, 6'h00, 1'b1, 0, K_BEQ, 2);   // beq taken
        run_instr(6'h05, 6'h00, 1'b1, 0, K_BNE, 2);   // bne not taken
        run_instr(6'h02, 6'h00, 1'b0, 0, K_J,   0);   // j
        run_instr(6'h03, 6'h00, 1'b0, 0, K_JAL, 0);   // jal
        run_instr(6'h3F, 6'h00, 1'b0, 0, K_ILL, 0);   // illegal opcode
        run_instr(6'h00, 6'h3F, 1'b0, 0, K_ILL, 0);   // illegal funct

        // Abort a lw in MEMRD with a two-cycle reset
        op = 6'h23; funct = 6'h00; mem_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (state == 4'd3) break;
            @(posedge clk); #1;
        end
        chk("reach_memrd", state, 3);
        rstn = 1'b0;
        #1;
        chk("midrst_strobes", {mem_re, mem_we, reg_we, pc_we}, 0);
        @(posedge clk);
        @(negedge clk);
        chk("midrst_state", state, 0);
        chk("midrst_retired", retired, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        exp_ret = '0;
        run_instr(6'h00, 6'h20, 1'b0, 0, K_R, 1);

        // 15 more retires: counter wraps 15 -> 0 on the 16th
        for (int i = 0; i < 15; i++) run_instr(6'h08, 6'h00, 1'b0, 0, K_I, 1);
        chk("wrap_zero", retired, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
